// File: rtl/bullet_scheduler.sv
// Bullet pool controller: allocates a free slot on each fire press, arbitrates the
// single VGA plot port round-robin among slots, and routes asteroid hits to bullets.
module bullet_scheduler #(
    parameter int          NUM_BULLETS     = 4,
    parameter logic [15:0] COOLDOWN_CYCLES = 16'd50000,
    parameter logic [2:0]  BULLET_COLOUR   = 3'b111
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     fire,
    input  logic [7:0]               ship_x,
    input  logic [6:0]               ship_y,
    input  logic [1:0]               ship_dir_x,
    input  logic [1:0]               ship_dir_y,
    input  logic [NUM_BULLETS-1:0]   slot_firing,
    input  logic [NUM_BULLETS-1:0]   slot_plot_req,
    input  logic [8*NUM_BULLETS-1:0] slot_x,
    input  logic [7*NUM_BULLETS-1:0] slot_y,
    input  logic                     hit_valid,
    input  logic [7:0]               hit_x,
    input  logic [6:0]               hit_y,
    output logic [NUM_BULLETS-1:0]   slot_load,
    output logic [NUM_BULLETS-1:0]   slot_shooting,
    output logic [7:0]               start_x,
    output logic [6:0]               start_y,
    output logic [1:0]               dir_x,
    output logic [1:0]               dir_y,
    output logic [NUM_BULLETS-1:0]   slot_collision,
    output logic [NUM_BULLETS-1:0]   plot_grant,
    output logic [7:0]               vga_x,
    output logic [6:0]               vga_y,
    output logic [2:0]               vga_colour,
    output logic                     vga_plot,
    output logic                     fire_denied,
    output logic [7:0]               shots_fired
);

    localparam int IW = $clog2(NUM_BULLETS);
    localparam logic [NUM_BULLETS-1:0] ONE_HOT0 = NUM_BULLETS'(1);
    localparam logic [IW:0]            NB       = (IW+1)'(NUM_BULLETS);
    localparam logic [IW-1:0]          LAST_IDX = IW'(NUM_BULLETS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ARM, COOL} fire_state_t;

    // Per-slot coordinate views and hit matching
    logic [7:0]             sx [NUM_BULLETS];
    logic [6:0]             sy [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] hit_match;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BULLETS; gi++) begin : g_slot
            assign sx[gi]        = slot_x[8*gi +: 8];
            assign sy[gi]        = slot_y[7*gi +: 7];
            assign hit_match[gi] = slot_firing[gi] && (sx[gi] == hit_x) && (sy[gi] == hit_y);
        end
    endgenerate

    // Fire path state
    fire_state_t            state_reg, state_next;
    logic                   fire_q_reg;
    logic [IW-1:0]          target_reg, target_next;
    logic [15:0]            cool_cnt_reg, cool_cnt_next;
    logic [7:0]             shots_reg, shots_next;
    logic [7:0]             start_x_reg, start_x_next;
    logic [6:0]             start_y_reg, start_y_next;
    logic [1:0]             dir_x_reg, dir_x_next;
    logic [1:0]             dir_y_reg, dir_y_next;
    logic [NUM_BULLETS-1:0] load_reg, load_next;
    logic [NUM_BULLETS-1:0] shoot_reg, shoot_next;
    logic                   denied_reg, denied_next;

    logic                   press;
    logic [NUM_BULLETS-1:0] target_onehot;
    logic [NUM_BULLETS-1:0] busy;
    logic                   free_found;
    logic [IW-1:0]          free_idx;

    assign press         = fire & ~fire_q_reg;
    assign target_onehot = ONE_HOT0 << target_reg;
    // The latched target is not yet reported as firing while it is being launched
    assign busy = slot_firing |
                  (((state_reg == LOAD) || (state_reg == ARM)) ? target_onehot : '0);

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!busy[IW'(i)]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        target_next   = target_reg;
        cool_cnt_next = cool_cnt_reg;
        shots_next    = shots_reg;
        start_x_next  = start_x_reg;
        start_y_next  = start_y_reg;
        dir_x_next    = dir_x_reg;
        dir_y_next    = dir_y_reg;
        load_next     = '0;
        shoot_next    = '0;
        denied_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (press) begin
                    if (free_found) begin
                        target_next  = free_idx;
                        start_x_next = ship_x;
                        start_y_next = ship_y;
                        dir_x_next   = ship_dir_x;
                        dir_y_next   = ship_dir_y;
                        state_next   = LOAD;
                    end else begin
                        denied_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                load_next  = target_onehot;
                shots_next = shots_reg + 8'd1;
                state_next = ARM;
            end
            ARM: begin
                shoot_next = target_onehot;
                if (COOLDOWN_CYCLES == 16'd0) begin
                    state_next = IDLE;
                end else begin
                    state_next    = COOL;
                    cool_cnt_next = COOLDOWN_CYCLES;
                end
            end
            COOL: begin
                if (cool_cnt_reg <= 16'd1) begin
                    state_next    = IDLE;
                    cool_cnt_next = 16'd0;
                end else begin
                    cool_cnt_next = cool_cnt_reg - 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            fire_q_reg   <= 1'b0;
            target_reg   <= '0;
            cool_cnt_reg <= 16'd0;
            shots_reg    <= 8'd0;
            start_x_reg  <= 8'd0;
            start_y_reg  <= 7'd0;
            dir_x_reg    <= 2'd0;
            dir_y_reg    <= 2'd0;
            load_reg     <= '0;
            shoot_reg    <= '0;
            denied_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fire_q_reg   <= fire;
            target_reg   <= target_next;
            cool_cnt_reg <= cool_cnt_next;
            shots_reg    <= shots_next;
            start_x_reg  <= start_x_next;
            start_y_reg  <= start_y_next;
            dir_x_reg    <= dir_x_next;
            dir_y_reg    <= dir_y_next;
            load_reg     <= load_next;
            shoot_reg    <= shoot_next;
            denied_reg   <= denied_next;
        end
    end

    // Plot arbiter: search starts at the round-robin pointer and wraps
    logic [IW-1:0]          rr_ptr_reg, rr_ptr_next;
    logic                   grant_found;
    logic [IW-1:0]          grant_idx;
    logic [IW:0]            rr_sum;
    logic [IW-1:0]          rr_idx;
    logic [NUM_BULLETS-1:0] grant_reg;
    logic                   vga_plot_reg;
    logic [7:0]             vga_x_reg;
    logic [6:0]             vga_y_reg;
    logic [2:0]             vga_colour_reg;
    logic [NUM_BULLETS-1:0] collision_reg, collision_next;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_sum      = '0;
        rr_idx      = '0;
        for (int off = 0; off < NUM_BULLETS; off++) begin
            rr_sum = {1'b0, rr_ptr_reg} + (IW+1)'(off);
            if (rr_sum >= NB) begin
                rr_sum = rr_sum - NB;
            end
            rr_idx = rr_sum[IW-1:0];
            if (!grant_found && slot_plot_req[rr_idx]) begin
                grant_found = 1'b1;
                grant_idx   = rr_idx;
            end
        end
        rr_ptr_next = rr_ptr_reg;
        if (grant_found) begin
            rr_ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + IW'(1);
        end
    end

    // Isolate the lowest matching slot so one hit kills at most one bullet
    assign collision_next = hit_valid ? (hit_match & (~hit_match + ONE_HOT0)) : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_reg     <= '0;
            grant_reg      <= '0;
            vga_plot_reg   <= 1'b0;
            vga_x_reg      <= 8'd0;
            vga_y_reg      <= 7'd0;
            vga_colour_reg <= 3'd0;
            collision_reg  <= '0;
        end else begin
            rr_ptr_reg    <= rr_ptr_next;
            collision_reg <= collision_next;
            vga_plot_reg  <= grant_found;
            if (grant_found) begin
                grant_reg      <= ONE_HOT0 << grant_idx;
                vga_x_reg      <= sx[grant_idx];
                vga_y_reg      <= sy[grant_idx];
                vga_colour_reg <= BULLET_COLOUR;
            end else begin
                grant_reg <= '0;
            end
        end
    end

    assign slot_load      = load_reg;
    assign slot_shooting  = shoot_reg;
    assign start_x        = start_x_reg;
    assign start_y        = start_y_reg;
    assign dir_x          = dir_x_reg;
    assign dir_y          = dir_y_reg;
    assign fire_denied    = denied_reg;
    assign shots_fired    = shots_reg;
    assign slot_collision = collision_reg;
    assign plot_grant     = grant_reg;
    assign vga_plot       = vga_plot_reg;
    assign vga_x          = vga_x_reg;
    assign vga_y          = vga_y_reg;
    assign vga_colour     = vga_colour_reg;

endmodule

// File: doc/bullet_scheduler.md
# bullet_scheduler

Controller for a pool of `bullet` instances in the Asteroids datapath. It allocates a free bullet slot on each fire press and launches it from the ship's position and heading. It arbitrates the single VGA plot port among bullet slots with a round-robin grant, and routes asteroid hit reports to the matching in-flight bullet as a collision pulse. It sits between the ship/input logic, the `bullet` array and the VGA adapter write port.

## Interface
- `NUM_BULLETS`, 4: slot count (2..8).
- `COOLDOWN_CYCLES`, 16'd50000: dead time after each launch before another fire press is accepted.
- `BULLET_COLOUR`, 3'b111: colour driven on `vga_colour` with every plot.
- `clk` in 1: system clock (CLOCK_50).
- `resetn` in 1: asynchronous, active-low reset.
- `fire` in 1: fire button level; the block acts on its rising edge.
- `ship_x` in 8, `ship_y` in 7: ship position, used as the launch point.
- `ship_dir_x` in 2, `ship_dir_y` in 2: ship heading, passed to the bullet unmodified.
- `slot_firing` in NUM_BULLETS: per-slot `firing` flags from the bullets.
- `slot_plot_req` in NUM_BULLETS: per-slot `plot_bullet` requests.
- `slot_x` in 8*NUM_BULLETS, `slot_y` in 7*NUM_BULLETS: flattened per-slot `curr_x`/`curr_y`; slot i occupies `[8i+7:8i]` and `[7i+6:7i]`.
- `hit_valid` in 1, `hit_x` in 8, `hit_y` in 7: single-cycle hit report from the asteroid logic.
- `slot_load` out NUM_BULLETS: one-hot load pulse.
- `slot_shooting` out NUM_BULLETS: one-hot shoot pulse.
- `start_x` out 8, `start_y` out 7, `dir_x` out 2, `dir_y` out 2: launch parameters, broadcast to all slots.
- `slot_collision` out NUM_BULLETS: one-hot collision pulse.
- `plot_grant` out NUM_BULLETS: one-hot grant pulse.
- `vga_x` out 8, `vga_y` out 7, `vga_colour` out 3, `vga_plot` out 1: VGA adapter write port.
- `fire_denied` out 1: pulses when a fire press is dropped because every slot is busy.
- `shots_fired` out 8: launch counter.

## Operation
- Fire edge detection: `fire_q` holds last cycle's `fire`. A press is `fire & ~fire_q`.
- Fire FSM states: IDLE, LOAD, ARM, COOL.
  - IDLE, press seen, free slot exists: latch the target slot k and snapshot `ship_x/y` and `ship_dir_x/y` into `start_x/y` and `dir_x/y`. Go to LOAD.
  - IDLE, press seen, no free slot: pulse `fire_denied` for 1 cycle and stay in IDLE.
  - LOAD: `slot_load[k]`=1 for exactly 1 cycle; `shots_fired` increments (8-bit, wraps 255 to 0). Go to ARM.
  - ARM: `slot_shooting[k]`=1 for exactly 1 cycle. Go to COOL with the counter loaded to COOLDOWN_CYCLES. If COOLDOWN_CYCLES is 0, go to IDLE instead.
  - COOL: decrement the counter each cycle; go to IDLE when it reaches 1.
  - Presses seen in LOAD, ARM or COOL are discarded. They are not queued and do not pulse `fire_denied`.
- Free slot: `slot_firing[i]`=0 and i is not the latched target k while in LOAD or ARM. The lowest free index wins.
- `start_x/y` and `dir_x/y` hold their value from the snapshot until the next launch.
- Plot arbiter:
  - Maintains a round-robin pointer p (reset 0).
  - Each cycle, the first requesting slot at or after p (wrapping) is granted. Registered outputs then give `plot_grant[g]`=1, `vga_plot`=1, `vga_x/y`=slot g's coordinates sampled on the grant edge, and `vga_colour`=BULLET_COLOUR.
  - After a grant, p becomes g+1 mod NUM_BULLETS.
  - No requests: `vga_plot`=0 and `plot_grant`=0. p is unchanged, and `vga_x/y/colour` hold their last value.
  - A slot keeps `slot_plot_req` high until it sees its grant. A request still high in the grant cycle is treated as a new request.
- Collision routing:
  - On `hit_valid`, match every slot with `slot_firing[i]`=1, `slot_x[i]`==`hit_x` and `slot_y[i]`==`hit_y`.
  - Only the lowest matching index gets `slot_collision`=1, for 1 cycle. No match produces no pulse.
- Fire, plot and collision paths are independent; the same slot may be loaded, granted and collided in the same cycle.

## Timing
- Reset value of every output is 0, except `vga_colour`, which is 0 until the first grant.
- On reset: FSM to IDLE, cooldown counter 0, p to 0, `fire_q` to 0.
- Reset assertion clears all pulses immediately, including mid-LOAD, mid-ARM and mid-COOL.
- After reset release, a `fire` held high from before reset counts as a press on the first cycle (`fire_q`=0).
- Fire latency: press sampled at edge 0 gives `slot_load` high after edge 1 and `slot_shooting` high after edge 2. COOL then lasts COOLDOWN_CYCLES cycles.
- Minimum spacing between two `slot_load` pulses is 2+COOLDOWN_CYCLES+1 cycles.
- Plot latency: a request sampled at edge t gives `vga_plot` in cycle t+1. A continuously requesting slot waits at most NUM_BULLETS cycles for a grant.
- Collision latency: `hit_valid` sampled at edge t gives `slot_collision` in cycle t+1.

## Test plan
- Reset, then a fire press with ship (79,59) and dirs (2'b01, 2'b10) -> `slot_load`=0001 at +1, `slot_shooting`=0001 at +2, `start_x`=79, `start_y`=59, `dir_x`=01, `dir_y`=10, `shots_fired`=1.
- COOLDOWN_CYCLES=4; second press 2 cycles after the first load, third press after COOL ends -> second press ignored, third loads slot 1 (`slot_firing`=0001 held).
- `slot_firing`=1111, press -> `fire_denied` pulses for 1 cycle, no `slot_load`, `shots_fired` unchanged.
- All four `slot_plot_req` held high with each slot dropping its request after its grant -> grants 0001, 0010, 0100, 1000 on consecutive cycles, `vga_plot`=1 each cycle, `vga_x/y` equal the granted slot's coordinates.
- Slots 1 and 3 firing, both at (40,30); `hit_valid` with (40,30) -> `slot_collision`=0010 for 1 cycle. Same hit with (41,30) -> no pulse.
- `resetn` low during ARM -> `slot_shooting` and all other outputs go to 0 immediately; after release, FSM in IDLE and `shots_fired`=0.
